loadq_sched: RTL

// - Control half of the load queue: allocates loadq_entry slots to incoming loads.
// - Round-robin arbitrates the entries' mem-pipe requests into one MEM_LOAD request per cycle.
// - Routes the mem-pipe grant back to the winning entry.
// - Sits between rename/dispatch (upstream) and the mem-pipe arbiter (downstream).
// - Instantiated once, alongside NUM_ENTRIES loadq_entry instances.

---
 rtl/loadq_sched_pkg.sv | 50 +++++
 rtl/loadq_sched_rr_arb.sv | 53 +++++
 rtl/loadq_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/loadq_sched_pkg.sv
// Shared load-queue types: slot ids, static load info, mem-pipe request packet,
// plus the find-first and popcount helpers used by the scheduler.
package loadq_sched_pkg;

    localparam int LDQ_NUM_ENTRIES = 8;
    localparam int LDQ_IDX_W       = $clog2(LDQ_NUM_ENTRIES);

    typedef logic [LDQ_IDX_W-1:0] t_ldq_id;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [6:0]  robid;
        logic [6:0]  pdst;
        logic [15:0] simid;
    } t_ldq_static;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_FILL  = 2'd3
    } t_mempipe_op;

    typedef struct packed {
        t_mempipe_op op;
        t_ldq_id     id;
        logic [6:0]  robid;
        logic [31:0] vaddr;
    } t_mempipe_arb;

    // Helpers take a 64-bit vector so any queue depth up to 64 can zero-extend into them.
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [5:0] find_first64(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/loadq_sched_rr_arb.sv
// Round-robin arbiter: picks the first request at or after rr_ptr (wrapping) and
// advances the pointer past the winner only when the downstream grant arrives.
module loadq_sched_rr_arb #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             gnt_en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] probe;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        probe  = '0;
        for (int i = 0; i < N; i++) begin
            probe = rr_ptr_q + IDX_W'(i);
            if (!found && req[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

    always_comb begin
        any_req  = reset & (|req);
        gnt      = ({{(N-1){1'b0}}, 1'b1} << winner) & {N{gnt_en & any_req}};
        rr_ptr_d = rr_ptr_q;
        if (gnt_en && any_req) begin
            rr_ptr_d = winner + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/loadq_sched.sv
// Load-queue control: allocates free slots to dispatched loads, tracks occupancy,
// and funnels the entries' mem-pipe requests through a round-robin arbiter.
module loadq_sched
    import loadq_sched_pkg::*;
#(
    parameter  int NUM_ENTRIES = LDQ_NUM_ENTRIES,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = IDX_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_req_mm0,
    input  t_ldq_static            alloc_static_mm0,
    output logic                   alloc_gnt_mm0,
    output logic [IDX_W-1:0]       alloc_id_mm0,
    output logic                   ldq_full,
    output logic [CNT_W-1:0]       ldq_count,
    input  logic [NUM_ENTRIES-1:0] e_valid,
    output logic [NUM_ENTRIES-1:0] e_alloc_mm0,
    output t_ldq_static            q_alloc_static_mm0,
    input  logic [NUM_ENTRIES-1:0] e_pipe_req_mm0,
    input  t_mempipe_arb           e_pipe_req_pkt_mm0 [NUM_ENTRIES],
    output logic [NUM_ENTRIES-1:0] e_pipe_gnt_mm0,
    output logic                   ldq_pipe_req_mm0,
    output t_mempipe_arb           ldq_pipe_req_pkt_mm0,
    input  logic                   ldq_pipe_gnt_mm0
);

    logic [NUM_ENTRIES-1:0] e_valid_q, e_valid_d;
    logic [NUM_ENTRIES-1:0] e_alloc_q, e_alloc_d;
    logic [CNT_W-1:0]       ldq_count_q, ldq_count_d;
    logic                   ldq_full_q, ldq_full_d;

    logic [NUM_ENTRIES-1:0] free;
    logic [NUM_ENTRIES-1:0] dealloc;
    logic [NUM_ENTRIES-1:0] pkt_sel;
    logic [IDX_W-1:0]       winner;

    // A slot stays busy through the cycle its e_valid falls, so it can only be reused afterwards.
    always_comb begin
        free          = ~e_valid & ~e_valid_q & ~e_alloc_q;
        alloc_gnt_mm0 = reset & alloc_req_mm0 & (|free);
        alloc_id_mm0  = reset ? IDX_W'(find_first64(64'(free))) : '0;
        e_alloc_mm0   = ({{(NUM_ENTRIES-1){1'b0}}, 1'b1} << alloc_id_mm0)
                      & {NUM_ENTRIES{alloc_gnt_mm0}};
        q_alloc_static_mm0 = alloc_static_mm0;
    end

    always_comb begin
        dealloc     = e_valid_q & ~e_valid;
        ldq_count_d = ldq_count_q + CNT_W'(alloc_gnt_mm0)
                    - CNT_W'(popcount64(64'(dealloc)));
        ldq_full_d  = (ldq_count_d == CNT_W'(NUM_ENTRIES));
        e_valid_d   = e_valid;
        e_alloc_d   = e_alloc_mm0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid_q   <= '0;
            e_alloc_q   <= '0;
            ldq_count_q <= '0;
            ldq_full_q  <= 1'b0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_alloc_q   <= e_alloc_d;
            ldq_count_q <= ldq_count_d;
            ldq_full_q  <= ldq_full_d;
        end
    end

    assign ldq_count = ldq_count_q;
    assign ldq_full  = ldq_full_q;

    loadq_sched_rr_arb #(.N(NUM_ENTRIES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (e_pipe_req_mm0),
        .gnt_en  (ldq_pipe_gnt_mm0),
        .gnt     (e_pipe_gnt_mm0),
        .winner  (winner),
        .any_req (ldq_pipe_req_mm0)
    );

    // Packet select ignores the downstream grant: the winner's packet is shown while it waits.
    always_comb begin
        pkt_sel              = ({{(NUM_ENTRIES-1){1'b0}}, ldq_pipe_req_mm0}) << winner;
        ldq_pipe_req_pkt_mm0 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (pkt_sel[i]) begin
                ldq_pipe_req_pkt_mm0 = t_mempipe_arb'(ldq_pipe_req_pkt_mm0 | e_pipe_req_pkt_mm0[i]);
            end
        end
    end

    a_alloc_legal: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(e_alloc_mm0) && ((e_alloc_mm0 & e_valid) == '0));

    a_pipe_gnt_legal: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(e_pipe_gnt_mm0) && ((e_pipe_gnt_mm0 & ~e_pipe_req_mm0) == '0));

    a_full_agrees: assert property (@(posedge clk) disable iff (!reset)
        ldq_full_q == (free == '0));

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        (ldq_count_q <= CNT_W'(NUM_ENTRIES))
        && (CNT_W'(popcount64(64'(dealloc))) <= ldq_count_q));

    a_count_tracks: assert property (@(posedge clk) disable iff (!reset)
        ((e_valid == e_valid_q) && (e_alloc_q == '0))
        |-> (ldq_count_q == CNT_W'(popcount64(64'(e_valid)))));

    a_gnt_has_req: assert property (@(posedge clk) disable iff (!reset)
        ldq_pipe_gnt_mm0 |-> ldq_pipe_req_mm0);

endmodule
